conv_layer_sched: RTL
=====================

# conv_layer_sched

Layer-level scheduler that sequences the 3x3 convolve engine across a full feature map. For each kernel bank and each output row band it requests a three-row line-buffer fill, pulses the engine's start, waits for its done, and advances the destination base address. It sits between the NPU top-level control and the convolve engine plus line-buffer loader. It also provides a done watchdog and a synchronous abort.

## Interface
- ROWS, 28: input feature-map rows and columns (square); supported range 3..31.
- DADDR_W, 12: destination address width.
- KB_W, 3: kernel-bank index width.
- TIMEOUT, 1023: maximum cycles spent in WAIT before the watchdog error fires.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- layer_start  in  1  one-cycle request to run a layer; honoured only in IDLE.
- layer_abort  in  1  synchronous abort.
- cfg_stride  in  2  convolution stride; 1 or 2 are legal; sampled at layer_start.
- cfg_num_kernels  in  KB_W  number of kernel banks to run, 1..2^KB_W-1; sampled at layer_start.
- cfg_dest_base  in  DADDR_W  first destination address; sampled at layer_start.
- row_req  out  1  line-buffer fill request.
- row_idx  out  5  top source row of the band (rows row_idx..row_idx+2).
- row_ack  in  1  loader finished the fill.
- conv_start  out  1  one-cycle engine start.
- conv_stride  out  2  latched stride forwarded to the engine.
- conv_done  in  1  engine completion.
- conv_dest_addr  out  DADDR_W  output-row base address for the current job.
- kernel_bank  out  KB_W  current kernel bank index.
- layer_busy  out  1  high in every state except IDLE.
- layer_done  out  1  one-cycle pulse on normal completion.
- err  out  1  sticky error flag.

## Operation
- Derived values, fixed at the accepted layer_start:
  - OR = (ROWS-3)/stride + 1 output rows; for ROWS=28 this is 26 (stride 1) or 13 (stride 2).
  - OC = OR output columns.
- Loop order: kernel bank k = 0..nk-1 (outer), band b = 0..OR-1 (inner).
  - row_idx = b*stride.
  - kernel_bank = k.
  - conv_dest_addr = cfg_dest_base + (k*OR + b)*OC, computed incrementally by adding OC per job. Arithmetic is modulo 2^DADDR_W.
- States:
  - IDLE: waits for a legal layer_start, then goes to FETCH.
    - Illegal stride (0 or 3) or cfg_num_kernels=0: set err, stay in IDLE, layer_busy stays 0.
    - A legal start clears err.
  - FETCH: row_req=1 and row_idx valid. On row_ack=1 go to START.
  - START: conv_start=1 for exactly this cycle, then go to WAIT.
  - WAIT: the watchdog counts cycles.
    - conv_done=1 goes to ADVANCE.
    - If the count reaches TIMEOUT: set err and go to IDLE with no layer_done.
  - ADVANCE: increment b. If b was OR-1, set b=0 and increment k. If that was the last job go to DONE, otherwise go to FETCH.
  - DONE: layer_done=1 for one cycle, then go to IDLE.
- Ignored inputs:
  - row_ack outside FETCH.
  - conv_done outside WAIT, including conv_done in the START cycle.
  - layer_start outside IDLE.
- layer_abort in any non-IDLE state:
  - Next state is IDLE; all handshake outputs go to 0 next cycle.
  - No layer_done; err is unchanged.
  - Abort in IDLE has no effect.
  - Abort has priority over row_ack, conv_done and the timeout in the same cycle.
- Reset values: state=IDLE; every output 0, including conv_stride, conv_dest_addr, kernel_bank, row_idx and err.
- Reset mid-layer: immediate return to IDLE; no layer_done pulse after release.

## Timing
- All outputs are registered and change only on clk edges (apart from asynchronous reset).
- layer_start sampled at edge 0 gives layer_busy=1 and row_req=1 from edge 1.
- row_req stays high until the edge that samples row_ack=1; it is low in the following START cycle.
- Back-to-back latency with zero-wait handshakes:
  - FETCH, START, WAIT, then ADVANCE the cycle after conv_done, then FETCH the next cycle.
  - Scheduler overhead is 3 cycles per job beyond the engine time.
- row_idx, kernel_bank and conv_dest_addr:
  - Updated in ADVANCE.
  - Stable from FETCH entry through WAIT exit.
- conv_stride is updated only at an accepted layer_start and held until the next one.
- layer_done is high in the same cycle that layer_busy is still 1; layer_busy falls on the next edge.
- The watchdog counter clears on WAIT entry; err asserts on the edge where count==TIMEOUT.

## Test plan
- Stride 1, nk=1, base 0, ROWS=28, ack and done returned 2 cycles after each request -> exactly 26 conv_start pulses; row_idx 0..25; dest 0,26,..,650; one layer_done.
- Stride 2, nk=2, base 100 -> 26 jobs; row_idx 0,2,..,24 repeated twice; kernel_bank 0 then 1; last dest 100+25*13=425.
- cfg_stride=3 or cfg_num_kernels=0 at start -> err=1, layer_busy stays 0, no row_req; a following legal start clears err.
- conv_done withheld in WAIT -> err=1 after TIMEOUT cycles, return to IDLE, no layer_done; a spurious conv_done during FETCH is ignored.
- layer_abort asserted together with conv_done in WAIT -> IDLE next cycle, all outputs 0, no layer_done; a new start restarts from row_idx 0 and base.
- Reset asserted mid-WAIT -> all outputs 0 immediately; after release, stays IDLE until layer_start.

Source files
------------

// File: rtl/conv_layer_sched_if.sv
// Handshake bundle between the layer scheduler, its controller, the line-buffer
// loader and the convolve engine. The slave modport is the scheduler's view.
interface conv_layer_sched_if #(
  parameter int DADDR_W = 12,
  parameter int KB_W    = 3
);
  logic               layer_start;
  logic               layer_abort;
  logic [1:0]         cfg_stride;
  logic [KB_W-1:0]    cfg_num_kernels;
  logic [DADDR_W-1:0] cfg_dest_base;
  logic               row_req;
  logic [4:0]         row_idx;
  logic               row_ack;
  logic               conv_start;
  logic [1:0]         conv_stride;
  logic               conv_done;
  logic [DADDR_W-1:0] conv_dest_addr;
  logic [KB_W-1:0]    kernel_bank;
  logic               layer_busy;
  logic               layer_done;
  logic               err;

  modport master (
    output layer_start, layer_abort, cfg_stride, cfg_num_kernels, cfg_dest_base,
    output row_ack, conv_done,
    input  row_req, row_idx, conv_start, conv_stride, conv_dest_addr,
    input  kernel_bank, layer_busy, layer_done, err
  );

  modport slave (
    input  layer_start, layer_abort, cfg_stride, cfg_num_kernels, cfg_dest_base,
    input  row_ack, conv_done,
    output row_req, row_idx, conv_start, conv_stride, conv_dest_addr,
    output kernel_bank, layer_busy, layer_done, err
  );
endinterface

// File: rtl/conv_layer_sched.sv
// Sequences the 3x3 convolve engine over every (kernel bank, output row band)
// pair of a layer, with a WAIT-state watchdog and a synchronous abort.
module conv_layer_sched #(
  parameter int ROWS    = 28,
  parameter int DADDR_W = 12,
  parameter int KB_W    = 3,
  parameter int TIMEOUT = 1023
) (
  input logic               clk,
  input logic               rst_n,
  conv_layer_sched_if.slave bus
);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int OR_S1 = ROWS - 2;
  localparam int OR_S2 = (ROWS - 3) / 2 + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_WAIT, S_ADVANCE, S_DONE
  } state_t;

  state_t             r_state;
  logic [1:0]         r_stride;
  logic [KB_W-1:0]    r_nk;
  logic [KB_W-1:0]    r_k;
  logic [4:0]         r_or;
  logic [4:0]         r_b;
  logic [4:0]         r_row_idx;
  logic [DADDR_W-1:0] r_dest;
  logic [WD_W-1:0]    r_wdog;
  logic               r_row_req;
  logic               r_conv_start;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_cfg_ok;
  logic [4:0]         w_or;
  logic [DADDR_W-1:0] w_oc;

  assign w_cfg_ok = ((bus.cfg_stride == 2'd1) || (bus.cfg_stride == 2'd2)) &&
                    (bus.cfg_num_kernels != '0);
  assign w_or     = (bus.cfg_stride == 2'd2) ? 5'(OR_S2) : 5'(OR_S1);
  // Output maps are square, so one output row spans OR addresses.
  assign w_oc     = DADDR_W'(r_or);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_stride     <= '0;
      r_nk         <= '0;
      r_k          <= '0;
      r_or         <= '0;
      r_b          <= '0;
      r_row_idx    <= '0;
      r_dest       <= '0;
      r_wdog       <= '0;
      r_row_req    <= 1'b0;
      r_conv_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else if (r_state != S_IDLE && bus.layer_abort) begin
      r_state      <= S_IDLE;
      r_row_req    <= 1'b0;
      r_conv_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_row_idx    <= '0;
      r_k          <= '0;
      r_dest       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.layer_start) begin
            if (w_cfg_ok) begin
              r_stride  <= bus.cfg_stride;
              r_nk      <= bus.cfg_num_kernels;
              r_or      <= w_or;
              r_k       <= '0;
              r_b       <= '0;
              r_row_idx <= '0;
              r_dest    <= bus.cfg_dest_base;
              r_err     <= 1'b0;
              r_busy    <= 1'b1;
              r_row_req <= 1'b1;
              r_state   <= S_FETCH;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (bus.row_ack) begin
            r_row_req    <= 1'b0;
            r_conv_start <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_conv_start <= 1'b0;
          r_wdog       <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.conv_done) begin
            r_state <= S_ADVANCE;
          end else if (r_wdog == WD_W'(TIMEOUT)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_ADVANCE: begin
          if (r_b == r_or - 5'd1) begin
            if (r_k == r_nk - KB_W'(1)) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_b       <= '0;
              r_k       <= r_k + KB_W'(1);
              r_row_idx <= '0;
              r_dest    <= r_dest + w_oc;
              r_row_req <= 1'b1;
              r_state   <= S_FETCH;
            end
          end else begin
            r_b       <= r_b + 5'd1;
            r_row_idx <= r_row_idx + {3'b000, r_stride};
            r_dest    <= r_dest + w_oc;
            r_row_req <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.row_req        = r_row_req;
  assign bus.row_idx        = r_row_idx;
  assign bus.conv_start     = r_conv_start;
  assign bus.conv_stride    = r_stride;
  assign bus.conv_dest_addr = r_dest;
  assign bus.kernel_bank    = r_k;
  assign bus.layer_busy     = r_busy;
  assign bus.layer_done     = r_done;
  assign bus.err            = r_err;
endmodule
